// File: rtl/seq_add_pkg.sv
// Shared definitions for the byte-serial adder: FSM state encoding,
// the adder slice width and a helper for sizing the byte index.
package seq_add_pkg;

    // Width of the shared adder slice; operands are processed this many bits per cycle.
    localparam int SLICE_W = 8;

    // Controller state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Byte index width: clog2 of the slice count, never narrower than one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/csa_8.sv
// 8-bit carry-select adder slice. The low nibble ripples normally while the
// high nibble is precomputed for both possible carries and then selected.
module csa_8
    import seq_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int H = SLICE_W / 2;

    logic [H:0] lo_sum;
    logic [H:0] hi_sum0;
    logic [H:0] hi_sum1;

    // Low half plus both speculative high halves, then pick by the low-half carry.
    always_comb begin
        lo_sum  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
        hi_sum0 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]};
        hi_sum1 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]} + {{H{1'b0}}, 1'b1};
        if (lo_sum[H]) begin
            sum  = {hi_sum1[H-1:0], lo_sum[H-1:0]};
            cout = hi_sum1[H];
        end else begin
            sum  = {hi_sum0[H-1:0], lo_sum[H-1:0]};
            cout = hi_sum0[H];
        end
    end

endmodule

// File: rtl/seq_add_ctrl.sv
// Byte-serial adder controller: one shared csa_8 slice adds two W-bit
// operands LSB byte first, one byte per cycle, then publishes the sum.
// Optional feature macro SEQ_ADD_SUB_EN adds a 'sub' input (subtract mode)
// and an 'overflow' output (signed overflow of the top slice).
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = SLICE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout
`ifdef SEQ_ADD_SUB_EN
    ,
    output logic         overflow
`endif
);

    localparam int                IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    logic [1:0]                           state;
    logic [IDX_W-1:0]                     idx;
    logic                                 carry;
    logic [NBYTES-1:0][SLICE_W-1:0]       a_reg;
    logic [NBYTES-1:0][SLICE_W-1:0]       b_reg;
    logic [NBYTES-1:0][SLICE_W-1:0]       acc;
    logic [NBYTES-1:0][SLICE_W-1:0]       acc_next;
    logic [SLICE_W-1:0]                   a_byte;
    logic [SLICE_W-1:0]                   b_byte;
    logic [SLICE_W-1:0]                   sum_byte;
    logic                                 slice_cout;
    logic                                 accept;
    logic                                 start_carry;
    logic                                 last_slice;
`ifdef SEQ_ADD_SUB_EN
    logic                                 sub_reg;
    logic                                 ovf_next;
`endif

    // Handshake outputs are pure decodes of the current state.
    always_comb begin
        ready      = (state == IDLE) || (state == DONE);
        busy       = (state == RUN);
        done       = (state == DONE);
        accept     = start && ready;
        last_slice = (idx == LAST_IDX);
    end

    // Select the current byte of each operand and the carry to seed a new operation.
`ifdef SEQ_ADD_SUB_EN
    always_comb begin
        a_byte      = a_reg[idx];
        b_byte      = sub_reg ? ~b_reg[idx] : b_reg[idx];
        start_carry = sub ? 1'b1 : cin;
        ovf_next    = (a_byte[SLICE_W-1] == b_byte[SLICE_W-1]) &&
                      (sum_byte[SLICE_W-1] != a_byte[SLICE_W-1]);
    end
`else
    always_comb begin
        a_byte      = a_reg[idx];
        b_byte      = b_reg[idx];
        start_carry = cin;
    end
`endif

    csa_8 u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .sum  (sum_byte),
        .cout (slice_cout)
    );

    // Accumulator with the current slice sum merged in, so the final byte can be published directly.
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = sum_byte;
    end

    // Controller FSM: accept in IDLE/DONE, run NBYTES slices, pulse DONE for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= RUN;
                RUN:     if (last_slice) state <= DONE;
                DONE:    state <= accept ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: latch operands on accept, step one slice per RUN cycle, publish on the last slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            result   <= '0;
            cout     <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
            sub_reg  <= 1'b0;
            overflow <= 1'b0;
`endif
        end else if (accept) begin
            a_reg    <= op_a;
            b_reg    <= op_b;
            idx      <= '0;
            carry    <= start_carry;
`ifdef SEQ_ADD_SUB_EN
            sub_reg  <= sub;
`endif
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= slice_cout;
            if (last_slice) begin
                result   <= acc_next;
                cout     <= slice_cout;
`ifdef SEQ_ADD_SUB_EN
                overflow <= ovf_next;
`endif
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Self-checking bench for seq_add_ctrl (NBYTES=4). Expected results are
// queued when a start is accepted and compared whenever done pulses.
// Build with SEQ_ADD_SUB_EN defined to also exercise subtract mode.
module tb_seq_add_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SEQ_ADD_SUB_EN
    logic         sub;
    logic         overflow;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] res;
        logic         co;
    } vec_t;

    exp_t         sb[$];
    vec_t         vecs[8];
    int           checks    = 0;
    int           failures  = 0;
    int           cyc       = 0;
    int           done_seen = 0;
    logic [W-1:0] last_res  = '0;

    seq_add_ctrl #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef SEQ_ADD_SUB_EN
        .sub      (sub),
`endif
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout)
`ifdef SEQ_ADD_SUB_EN
        ,
        .overflow (overflow)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to check done latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t modelAdd(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic ci, input logic sb_i);
        exp_t         e;
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   s;
        be    = sb_i ? ~b : b;
        c0    = sb_i ? 1'b1 : ci;
        s     = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
        e.res = s[W-1:0];
        e.co  = s[W];
        e.ov  = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
        e.cyc = 0;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("cout", cout, e.co);
                checkOutput("done_latency", cyc, e.cyc);
`ifdef SEQ_ADD_SUB_EN
                checkOutput("overflow", overflow, e.ov);
`endif
                last_res = e.res;
            end
        end
    end

    // Drive an accepted start at the current negedge (caller guarantees ready) and queue its result.
    task automatic driveStart(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                              input logic sb_i, input exp_t e);
        op_a  = a;
        op_b  = b;
        cin   = ci;
`ifdef SEQ_ADD_SUB_EN
        sub   = sb_i;
`endif
        start = 1'b1;
        e.cyc = cyc + NB + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                 input logic sb_i, input exp_t e);
        int budget = 0;
        @(negedge clk);
        while (!ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (!ready) begin
            checkOutput("ready_timeout", ready, 1);
            return;
        end
        driveStart(a, b, ci, sb_i, e);
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (sb.size() != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] prev;
        int           ds;
        int           budget;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
`ifdef SEQ_ADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_cout", cout, 0);
`ifdef SEQ_ADD_SUB_EN
        checkOutput("rst_overflow", overflow, 0);
`endif
        rst_n = 1'b1;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};

        for (int i = 0; i < 8; i++) begin
            e     = modelAdd(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0);
            e.res = vecs[i].res;
            e.co  = vecs[i].co;
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, e);
        end
        waitDrain();

        repeat (3) @(negedge clk);
        checkOutput("hold_result", result, last_res);
        checkOutput("idle_ready", ready, 1);
        checkOutput("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
            applyStimulus(a, b, ci, 1'b0, modelAdd(a, b, ci, 1'b0));
        end
        waitDrain();

        // Start while busy must be ignored and result must never show partial sums.
        prev = last_res;
        applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0,
                      modelAdd(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            op_a  = $urandom;
            op_b  = $urandom;
            cin   = 1'b1;
            checkOutput("busy_flag", busy, 1);
            checkOutput("busy_ready", ready, 0);
            checkOutput("no_partial", result, prev);
            @(negedge clk);
        end
        start = 1'b0;
        waitDrain();

        // Back-to-back: new start in the DONE cycle.
        applyStimulus(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0,
                      modelAdd(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0));
        budget = 0;
        while (!done && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!done) begin
            checkOutput("b2b_done_timeout", done, 1);
        end else begin
            e     = modelAdd(32'd5, 32'd7, 1'b0, 1'b0);
            e.res = 32'd12;
            e.co  = 1'b0;
            driveStart(32'd5, 32'd7, 1'b0, 1'b0, e);
        end
        waitDrain();
        checkOutput("b2b_result", result, 32'd12);

        // Reset mid-RUN abandons the operation with no done pulse.
        applyStimulus(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0,
                      modelAdd(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        ds = done_seen;
        repeat (2) @(negedge clk);
        checkOutput("midrun_rst_ready", ready, 1);
        checkOutput("midrun_rst_busy", busy, 0);
        checkOutput("midrun_rst_done", done, 0);
        checkOutput("midrun_rst_result", result, 0);
        checkOutput("midrun_rst_cout", cout, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("no_done_after_reset", 64'(done_seen - ds), 0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
                      modelAdd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0));
        waitDrain();
        checkOutput("recover_result", result, 32'hFFFF_FFFE);

`ifdef SEQ_ADD_SUB_EN
        e.res = 32'h7FFF_FFFF;
        e.co  = 1'b1;
        e.ov  = 1'b1;
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, e);
        e.res = 32'hFFFF_FFFE;
        e.co  = 1'b0;
        e.ov  = 1'b0;
        applyStimulus(32'd5, 32'd7, 1'b1, 1'b1, e);
        waitDrain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
